// File: rtl/alu_result_checker.sv
// Receiving-end checker for the 64-bit ALU datapath: recomputes each (op, a, b) result,
// compares it against y, counts passes/fails and captures the first mismatching vector.
module alu_result_checker #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail,
  output logic [2:0]       ff_op,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_y,
  output logic [WIDTH-1:0] ff_exp,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Handshake: a vector transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered state, never on in_valid.
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_num_vec_q;
  logic [CNT_W-1:0] r_accepted;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_first_fail;
  logic [2:0]       r_ff_op;
  logic [WIDTH-1:0] r_ff_a;
  logic [WIDTH-1:0] r_ff_b;
  logic [WIDTH-1:0] r_ff_y;
  logic [WIDTH-1:0] r_ff_exp;

  logic             r_s1_valid;
  logic             r_s1_illegal;
  logic [2:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [WIDTH-1:0] r_s1_y;
  logic [WIDTH-1:0] r_s1_exp;

  logic             w_ready;
  logic             w_accept;
  logic             w_match;
  logic             w_illegal;
  logic [WIDTH-1:0] w_exp;

  assign w_ready  = (r_state == S_RUN) && (r_accepted < r_num_vec_q);
  assign w_accept = in_valid && w_ready;
  assign w_match  = !r_s1_illegal && (r_s1_y == r_s1_exp);

  always_comb begin
    w_exp     = '0;
    w_illegal = 1'b0;
    case (op)
      3'b000:  w_exp = a + b;
      3'b001:  w_exp = a - b;
      3'b010:  w_exp = a & b;
      3'b011:  w_exp = a | b;
      3'b100:  w_exp = a ^ b;
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_num_vec_q  <= '0;
      r_accepted   <= '0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_first_fail <= 1'b0;
      r_ff_op      <= '0;
      r_ff_a       <= '0;
      r_ff_b       <= '0;
      r_ff_y       <= '0;
      r_ff_exp     <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_illegal <= 1'b0;
      r_s1_op      <= '0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_y       <= '0;
      r_s1_exp     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_illegal <= w_illegal;
        r_s1_op      <= op;
        r_s1_a       <= a;
        r_s1_b       <= b;
        r_s1_y       <= y;
        r_s1_exp     <= w_exp;
        r_accepted   <= r_accepted + CNT_ONE;
      end

      if (r_s1_valid) begin
        if (w_match) begin
          if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + CNT_ONE;
        end else begin
          if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_ONE;
          if (!r_first_fail) begin
            r_first_fail <= 1'b1;
            r_ff_op      <= r_s1_op;
            r_ff_a       <= r_s1_a;
            r_ff_b       <= r_s1_b;
            r_ff_y       <= r_s1_y;
            r_ff_exp     <= r_s1_exp;
          end
        end
      end

      // The pipeline is always empty outside RUN, so clearing here never races a compare.
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_RUN;
            r_num_vec_q  <= num_vec;
            r_accepted   <= '0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_first_fail <= 1'b0;
            r_ff_op      <= '0;
            r_ff_a       <= '0;
            r_ff_b       <= '0;
            r_ff_y       <= '0;
            r_ff_exp     <= '0;
          end
        end
        S_RUN: begin
          if ((r_accepted == r_num_vec_q) && !r_s1_valid) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = w_ready;
  assign pass_cnt   = r_pass_cnt;
  assign fail_cnt   = r_fail_cnt;
  assign first_fail = r_first_fail;
  assign ff_op      = r_ff_op;
  assign ff_a       = r_ff_a;
  assign ff_b       = r_ff_b;
  assign ff_y       = r_ff_y;
  assign ff_exp     = r_ff_exp;
  assign busy       = (r_state == S_RUN) || r_s1_valid;
  assign done       = (r_state == S_DONE);
  assign dbg_state  = r_state;

endmodule
